// File: rtl/frontend_pkg.sv
// Shared types and helpers for the decompression front end: bank occupancy
// and core-side states, a byte-enable popcount, and a width sanity check
// used by axis_pingpong_loader.
package frontend_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

  typedef enum logic {
    CORE_IDLE = 1'b0,
    CORE_BUSY = 1'b1
  } core_state_t;

  // Widest tkeep the popcount helper handles (DATA_W up to 1024 bits).
  localparam int POP_MAX_W = 128;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  // A frame length register must hold one full bank worth of bytes.
  function automatic bit len_w_ok(input int len_w, input int addr_w, input int data_w);
    return len_w >= addr_w + $clog2(data_w / 8) + 1;
  endfunction

endpackage

// File: rtl/axis_keep_count.sv
// Per-beat tkeep analysis: byte count of the beat and, when
// FRONTEND_KEEP_CHECK_EN is defined, a legality flag (non-last beats must be
// fully populated, the last beat must be a nonzero run of ones from byte 0).
module axis_keep_count
  import frontend_pkg::*;
#(
  parameter int KEEP_W = 32,
  parameter int CNT_W  = $clog2(KEEP_W) + 1
) (
  input  logic [KEEP_W-1:0] keep,
`ifdef FRONTEND_KEEP_CHECK_EN
  input  logic              last,
  output logic              keep_bad,
`endif
  output logic [CNT_W-1:0]  count
);

  assign count = CNT_W'(popcount(POP_MAX_W'(keep)));

`ifdef FRONTEND_KEEP_CHECK_EN
  logic [KEEP_W-1:0] keep_plus1;

  // A run of ones from the LSB turns into a single carry when incremented,
  // so ANDing with keep+1 leaves nothing behind.
  always_comb begin
    keep_plus1 = keep + KEEP_W'(1);
    if (last) begin
      keep_bad = (keep == '0) || ((keep & keep_plus1) != '0);
    end else begin
      keep_bad = (keep != '1);
    end
  end
`endif

endmodule

// File: rtl/axis_pingpong_loader.sv
// Double-buffered frame loader: writes AXI-Stream frames into alternating
// BRAM banks and dispatches completed frames to the decoder core with a
// start/finish handshake. Optional tkeep legality checking is compiled in
// with FRONTEND_KEEP_CHECK_EN; without it keep_err is tied low.
module axis_pingpong_loader
  import frontend_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 6,
  parameter int LEN_W  = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic                start,
  input  logic                finish,
  output logic                bank,
  output logic [LEN_W-1:0]    length,
  output logic                ovf,
  output logic                keep_err,
  output logic                bram_we,
  output logic [ADDR_W:0]     bram_addr,
  output logic [DATA_W-1:0]   bram_din
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(KEEP_W) + 1;

  if (!len_w_ok(LEN_W, ADDR_W, DATA_W)) begin : g_len_w_check
    $error("LEN_W is too narrow to hold a full bank of bytes");
  end

  logic              wr_bank;
  logic              rd_bank;
  bank_state_t       bank_st [2];
  core_state_t       core_st;
  core_state_t       core_nxt;
  logic              dispatch;
  logic              retire;

  logic [ADDR_W:0]   beat_cnt;
  logic [LEN_W-1:0]  len_acc;
  logic              ovf_acc;
  logic [LEN_W-1:0]  len_bank [2];
  logic              ovf_bank [2];

  logic              accept;
  logic              in_range;
  logic [CNT_W-1:0]  beat_bytes;
  logic [LEN_W-1:0]  len_next;

`ifdef FRONTEND_KEEP_CHECK_EN
  logic              beat_bad;
  logic              kerr_acc;
  logic              kerr_bank [2];
`endif

  axis_keep_count #(
    .KEEP_W (KEEP_W),
    .CNT_W  (CNT_W)
  ) u_keep_count (
    .keep     (s_axis_tkeep),
`ifdef FRONTEND_KEEP_CHECK_EN
    .last     (s_axis_tlast),
    .keep_bad (beat_bad),
`endif
    .count    (beat_bytes)
  );

  // The write side only stalls when the bank it points at still holds a frame;
  // held low during reset so every output reads zero.
  assign s_axis_tready = aresetn && (bank_st[wr_bank] == EMPTY);
  assign accept        = s_axis_tvalid && s_axis_tready;
  // beat_cnt saturates at DEPTH, so its top bit marks beats past the bank end.
  assign in_range      = !beat_cnt[ADDR_W];
  assign bram_we       = accept && in_range;
  assign bram_addr     = {wr_bank, beat_cnt[ADDR_W-1:0]};
  assign bram_din      = bram_we ? s_axis_tdata : '0;
  assign len_next      = len_acc + (in_range ? LEN_W'(beat_bytes) : '0);

  // Assemble the incoming frame and latch its summary into the bank it filled.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_bank     <= 1'b0;
      beat_cnt    <= '0;
      len_acc     <= '0;
      ovf_acc     <= 1'b0;
      len_bank[0] <= '0;
      len_bank[1] <= '0;
      ovf_bank[0] <= 1'b0;
      ovf_bank[1] <= 1'b0;
    end else if (accept) begin
      if (s_axis_tlast) begin
        len_bank[wr_bank] <= len_next;
        ovf_bank[wr_bank] <= ovf_acc | !in_range;
        wr_bank           <= !wr_bank;
        beat_cnt          <= '0;
        len_acc           <= '0;
        ovf_acc           <= 1'b0;
      end else begin
        if (in_range) begin
          beat_cnt <= beat_cnt + {{ADDR_W{1'b0}}, 1'b1};
        end
        len_acc <= len_next;
        ovf_acc <= ovf_acc | !in_range;
      end
    end
  end

  // Bank occupancy: filled by the stream side, emptied when the core retires it.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      rd_bank    <= 1'b0;
    end else begin
      if (accept && s_axis_tlast) begin
        bank_st[wr_bank] <= FULL;
      end
      if (retire) begin
        bank_st[rd_bank] <= EMPTY;
        rd_bank          <= !rd_bank;
      end
    end
  end

  // Core-side state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      core_st <= CORE_IDLE;
    end else begin
      core_st <= core_nxt;
    end
  end

  // Hand a full bank to an idle core; retire it on finish while busy.
  always_comb begin
    core_nxt = core_st;
    dispatch = 1'b0;
    retire   = 1'b0;
    case (core_st)
      CORE_IDLE: begin
        if (bank_st[rd_bank] == FULL) begin
          dispatch = 1'b1;
          core_nxt = CORE_BUSY;
        end
      end
      CORE_BUSY: begin
        if (finish) begin
          retire   = 1'b1;
          core_nxt = CORE_IDLE;
        end
      end
      default: core_nxt = CORE_IDLE;
    endcase
  end

  // Registered dispatch outputs, held from start until the next dispatch.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      start  <= 1'b0;
      bank   <= 1'b0;
      length <= '0;
      ovf    <= 1'b0;
    end else begin
      start <= dispatch;
      if (dispatch) begin
        bank   <= rd_bank;
        length <= len_bank[rd_bank];
        ovf    <= ovf_bank[rd_bank];
      end
    end
  end

`ifdef FRONTEND_KEEP_CHECK_EN
  // Accumulate tkeep violations per frame and report them with the dispatch.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      kerr_acc     <= 1'b0;
      kerr_bank[0] <= 1'b0;
      kerr_bank[1] <= 1'b0;
      keep_err     <= 1'b0;
    end else begin
      if (accept) begin
        if (s_axis_tlast) begin
          kerr_bank[wr_bank] <= kerr_acc | beat_bad;
          kerr_acc           <= 1'b0;
        end else begin
          kerr_acc <= kerr_acc | beat_bad;
        end
      end
      if (dispatch) begin
        keep_err <= kerr_bank[rd_bank];
      end
    end
  end
`else
  assign keep_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_pingpong_loader.sv
// Self-checking bench for axis_pingpong_loader. A frame-level reference model
// (queue of loaded frames plus the core's current frame) predicts tready,
// BRAM writes and dispatches every cycle; directed sequences and a table of
// single-beat frames cover the corner cases, then a random phase follows.
// Build with FRONTEND_KEEP_CHECK_EN to expect keep_err reporting.
`timescale 1ns/1ps
module tb_axis_pingpong_loader;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 6;
  localparam int LEN_W  = 16;
  localparam int KEEP_W = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;

`ifdef FRONTEND_KEEP_CHECK_EN
  localparam bit KEEP_CHECK = 1'b1;
`else
  localparam bit KEEP_CHECK = 1'b0;
`endif

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [DATA_W-1:0] tdata = '0;
  logic [KEEP_W-1:0] tkeep = '0;
  logic              tvalid = 1'b0;
  logic              tlast = 1'b0;
  logic              finish = 1'b0;
  logic              s_axis_tready;
  logic              start;
  logic              bank;
  logic [LEN_W-1:0]  length;
  logic              ovf;
  logic              keep_err;
  logic              bram_we;
  logic [ADDR_W:0]   bram_addr;
  logic [DATA_W-1:0] bram_din;

  axis_pingpong_loader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tvalid (tvalid),
    .s_axis_tlast  (tlast),
    .s_axis_tready (s_axis_tready),
    .start         (start),
    .finish        (finish),
    .bank          (bank),
    .length        (length),
    .ovf           (ovf),
    .keep_err      (keep_err),
    .bram_we       (bram_we),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic bank;
    int   len;
    bit   ovf;
    bit   kerr;
  } frame_t;

  typedef struct {
    logic [KEEP_W-1:0] keep;
    int                exp_len;
    logic              exp_bank;
    bit                exp_kerr;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model state
  frame_t loaded_q[$];
  bit     core_has = 1'b0;
  frame_t core_frame;
  bit     exp_start = 1'b0;
  logic   m_wr_bank = 1'b0;
  int     cur_beats = 0;
  int     cur_len = 0;
  bit     cur_ovf = 1'b0;
  bit     cur_kerr = 1'b0;

  // Values seen at the most recent sample point
  logic             obs_start;
  logic             obs_bank;
  logic [LEN_W-1:0] obs_len;
  logic             obs_ovf;
  logic             obs_kerr;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [KEEP_W-1:0] contig_keep(input int n);
    logic [KEEP_W:0] t;
    t = ({{KEEP_W{1'b0}}, 1'b1} << n) - {{KEEP_W{1'b0}}, 1'b1};
    return t[KEEP_W-1:0];
  endfunction

  function automatic bit beat_is_bad(input logic [KEEP_W-1:0] k, input bit l);
    int n;
    bit bad;
    n = $countones(k);
    if (l) bad = (n == 0) || (k != contig_keep(n));
    else   bad = (n != KEEP_W);
    return KEEP_CHECK && bad;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model by what the coming edge does.
  task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d,
                               input logic [KEEP_W-1:0] k, input bit l,
                               input bit f, output bit acc);
    bit     exp_tready;
    bit     exp_we;
    bit     do_dispatch;
    bit     do_retire;
    frame_t fr;
    tvalid = v;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    finish = f;
    @(negedge aclk);
    exp_tready = (loaded_q.size() + int'(core_has)) < 2;
    checkOutput("tready", s_axis_tready, exp_tready);
    checkOutput("start", start, exp_start);
    if (core_has) begin
      checkOutput("bank", bank, core_frame.bank);
      checkOutput("length", length, core_frame.len);
      checkOutput("ovf", ovf, core_frame.ovf);
      checkOutput("keep_err", keep_err, core_frame.kerr);
    end
    exp_we = v && exp_tready && (cur_beats < DEPTH);
    checkOutput("bram_we", bram_we, exp_we);
    if (exp_we) begin
      checkOutput("bram_addr", bram_addr, {m_wr_bank, ADDR_W'(cur_beats)});
      checkOutput("bram_din", bram_din, d);
    end
    obs_start = start;
    obs_bank  = bank;
    obs_len   = length;
    obs_ovf   = ovf;
    obs_kerr  = keep_err;

    acc         = v && exp_tready;
    do_dispatch = !core_has && (loaded_q.size() > 0);
    do_retire   = core_has && f;
    exp_start   = 1'b0;
    if (do_retire) core_has = 1'b0;
    if (do_dispatch) begin
      core_frame = loaded_q.pop_front();
      core_has   = 1'b1;
      exp_start  = 1'b1;
    end
    if (acc) begin
      if (cur_beats < DEPTH) cur_len += $countones(k);
      else cur_ovf = 1'b1;
      cur_kerr |= beat_is_bad(k, l);
      cur_beats++;
      if (l) begin
        fr.bank = m_wr_bank;
        fr.len  = cur_len;
        fr.ovf  = cur_ovf;
        fr.kerr = cur_kerr;
        loaded_q.push_back(fr);
        m_wr_bank = !m_wr_bank;
        cur_beats = 0;
        cur_len   = 0;
        cur_ovf   = 1'b0;
        cur_kerr  = 1'b0;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input bit f);
    bit acc;
    applyStimulus(1'b0, '0, '0, 1'b0, f, acc);
  endtask

  task automatic do_reset(input bit with_beat);
    aresetn = 1'b0;
    tvalid  = with_beat;
    tdata   = rand_data();
    tkeep   = '1;
    tlast   = 1'b0;
    finish  = 1'b0;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    checkOutput("rst_tready", s_axis_tready, 0);
    checkOutput("rst_start", start, 0);
    checkOutput("rst_bank", bank, 0);
    checkOutput("rst_length", length, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_keep_err", keep_err, 0);
    checkOutput("rst_bram_we", bram_we, 0);
    checkOutput("rst_bram_addr", bram_addr, 0);
    checkOutput("rst_bram_din", bram_din, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    tvalid  = 1'b0;
    loaded_q.delete();
    core_has  = 1'b0;
    exp_start = 1'b0;
    m_wr_bank = 1'b0;
    cur_beats = 0;
    cur_len   = 0;
    cur_ovf   = 1'b0;
    cur_kerr  = 1'b0;
  endtask

  // fin_mode: 0 never finish, 1 random finish while the core holds a frame,
  // 2 one finish pulse after four stalled cycles.
  task automatic send_frame(input int nbeats, input int mid_idx,
                            input logic [KEEP_W-1:0] mid_keep,
                            input logic [KEEP_W-1:0] last_keep, input int fin_mode);
    int beat = 0;
    int guard = 0;
    int stall = 0;
    bit acc;
    bit f;
    bit l;
    logic [KEEP_W-1:0] k;
    while (beat < nbeats && guard < 400) begin
      l = (beat == nbeats - 1);
      k = l ? last_keep : ((beat == mid_idx) ? mid_keep : '1);
      case (fin_mode)
        1:       f = core_has && ($urandom_range(0, 2) == 0);
        2:       f = (stall == 4);
        default: f = 1'b0;
      endcase
      applyStimulus(1'b1, rand_data(), k, l, f, acc);
      if (acc) begin
        beat++;
        stall = 0;
      end else begin
        stall++;
      end
      guard++;
    end
    if (beat < nbeats) failNow("send_frame_timeout", beat, nbeats);
  endtask

  task automatic drain();
    int guard = 0;
    while ((loaded_q.size() > 0 || core_has) && guard < 300) begin
      idle(core_has && ($urandom_range(0, 2) == 0));
      guard++;
    end
    if (guard >= 300) failNow("drain_timeout", loaded_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[7];
    bit acc;
    bit v;
    bit l;
    bit f;
    logic [KEEP_W-1:0] k;

    tbl[0] = '{keep: 32'hFFFF_FFFF, exp_len: 32, exp_bank: 1'b0, exp_kerr: 1'b0};
    tbl[1] = '{keep: 32'h0000_00FF, exp_len: 8,  exp_bank: 1'b1, exp_kerr: 1'b0};
    tbl[2] = '{keep: 32'h0000_0000, exp_len: 0,  exp_bank: 1'b0, exp_kerr: 1'b1};
    tbl[3] = '{keep: 32'h0000_0001, exp_len: 1,  exp_bank: 1'b1, exp_kerr: 1'b0};
    tbl[4] = '{keep: 32'h8000_0001, exp_len: 2,  exp_bank: 1'b0, exp_kerr: 1'b1};
    tbl[5] = '{keep: 32'hF0F0_F0F0, exp_len: 16, exp_bank: 1'b1, exp_kerr: 1'b1};
    tbl[6] = '{keep: 32'h0000_FFFF, exp_len: 16, exp_bank: 1'b0, exp_kerr: 1'b0};

    $display("[TB] reset");
    do_reset(1'b0);

    $display("[TB] three-beat frame");
    send_frame(3, -1, '1, 32'h0000_00FF, 0);
    idle(1'b0);
    checkOutput("t1_start_early", obs_start, 0);
    idle(1'b0);
    checkOutput("t1_start", obs_start, 1);
    checkOutput("t1_length", obs_len, 72);
    checkOutput("t1_bank", obs_bank, 0);
    idle(1'b1);

    $display("[TB] single-beat table");
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, rand_data(), tbl[i].keep, 1'b1, 1'b0, acc);
      idle(1'b0);
      idle(1'b0);
      checkOutput("tbl_start", obs_start, 1);
      checkOutput("tbl_length", obs_len, tbl[i].exp_len);
      checkOutput("tbl_bank", obs_bank, tbl[i].exp_bank);
      checkOutput("tbl_keep_err", obs_kerr, KEEP_CHECK && tbl[i].exp_kerr);
      idle(1'b1);
    end

    $display("[TB] back-to-back frames with stalled core");
    do_reset(1'b0);
    send_frame(2, -1, '1, '1, 0);
    send_frame(2, -1, '1, '1, 0);
    send_frame(2, -1, '1, '1, 2);
    drain();

    $display("[TB] oversized frame");
    do_reset(1'b0);
    send_frame(70, -1, '1, '1, 1);
    idle(1'b0);
    idle(1'b0);
    checkOutput("t3_start", obs_start, 1);
    checkOutput("t3_length", obs_len, 2048);
    checkOutput("t3_ovf", obs_ovf, 1);
    drain();

    $display("[TB] tlast and finish together");
    do_reset(1'b0);
    send_frame(1, -1, '1, '1, 0);
    idle(1'b0);
    idle(1'b0);
    checkOutput("t4_first_start", obs_start, 1);
    applyStimulus(1'b1, rand_data(), '1, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, rand_data(), 32'h0000_000F, 1'b1, 1'b1, acc);
    idle(1'b0);
    checkOutput("t4_start_gap", obs_start, 0);
    idle(1'b0);
    checkOutput("t4_start", obs_start, 1);
    checkOutput("t4_bank", obs_bank, 1);
    checkOutput("t4_length", obs_len, 36);
    drain();

    $display("[TB] tkeep legality");
    do_reset(1'b0);
    send_frame(3, 1, 32'hFFFF_FFFE, '1, 0);
    idle(1'b0);
    idle(1'b0);
    checkOutput("t5_length", obs_len, 95);
    checkOutput("t5_keep_err", obs_kerr, KEEP_CHECK);
    idle(1'b1);
    send_frame(2, -1, '1, '1, 0);
    idle(1'b0);
    idle(1'b0);
    checkOutput("t5_clean_keep_err", obs_kerr, 0);
    idle(1'b1);

    $display("[TB] reset mid-frame");
    do_reset(1'b0);
    applyStimulus(1'b1, rand_data(), '1, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, rand_data(), '1, 1'b0, 1'b0, acc);
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      checkOutput("t6_no_start", obs_start, 0);
    end
    send_frame(2, -1, '1, 32'h0000_00FF, 0);
    idle(1'b0);
    idle(1'b0);
    checkOutput("t6_start", obs_start, 1);
    checkOutput("t6_bank", obs_bank, 0);
    checkOutput("t6_length", obs_len, 40);
    idle(1'b1);

    $display("[TB] random traffic");
    do_reset(1'b0);
    for (int c = 0; c < 500; c++) begin
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 5) == 0);
      if (l) k = ($urandom_range(0, 3) == 0) ? KEEP_W'($urandom) : contig_keep($urandom_range(1, KEEP_W));
      else   k = ($urandom_range(0, 7) == 0) ? KEEP_W'($urandom) : '1;
      f = core_has ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      applyStimulus(v, rand_data(), k, l, f, acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
